// File: rtl/iq_gain_sweep.sv
// I/Q amplitude sweeper: scales a complex stream by a gain that ramps as a
// triangle between gain_min and gain_max, with round-half-up and saturation.
module iq_gain_sweep #(
    parameter int WIDTH  = 12,
    parameter int GWIDTH = 16,
    parameter int DWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [GWIDTH-1:0]        gain_min,
    input  logic [GWIDTH-1:0]        gain_max,
    input  logic [GWIDTH-1:0]        gain_step,
    input  logic [DWIDTH-1:0]        hold_div,
    input  logic signed [WIDTH-1:0]  i_in,
    input  logic signed [WIDTH-1:0]  q_in,
    input  logic                     valid_in,
    output logic signed [WIDTH-1:0]  i_out,
    output logic signed [WIDTH-1:0]  q_out,
    output logic                     valid_out,
    output logic                     sat,
    output logic [GWIDTH-1:0]        gain_out,
    output logic                     dir_out
);

    localparam int PW = WIDTH + GWIDTH + 1;
    localparam logic [GWIDTH-1:0]   UNITY = {1'b1, {(GWIDTH-1){1'b0}}};
    localparam logic signed [PW:0]  RND   = (PW+1)'(2**(GWIDTH-2));
    localparam logic signed [PW:0]  SMAX  = (PW+1)'(2**(WIDTH-1) - 1);
    localparam logic signed [PW:0]  SMIN  = (PW+1)'(-(2**(WIDTH-1)));

    logic [GWIDTH-1:0] gain_reg, gain_nxt, g_eff;
    logic              dir, dir_nxt, dir_eff;
    logic [DWIDTH-1:0] div_cnt, cnt_nxt, cnt_eff;
    logic              en_d, load;
    logic [GWIDTH:0]   up_sum, down_lim;

    logic signed [PW-1:0] p1_i, p1_q;
    logic                 v1;
    logic [WIDTH:0]       res_i, res_q;

    // A load cycle behaves as if the registers already held the start state.
    assign load     = en & ~en_d;
    assign g_eff    = load ? gain_min : gain_reg;
    assign dir_eff  = load ? 1'b1 : dir;
    assign cnt_eff  = load ? '0 : div_cnt;
    assign up_sum   = {1'b0, g_eff} + {1'b0, gain_step};
    assign down_lim = {1'b0, gain_min} + {1'b0, gain_step};

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        gain_nxt = gain_reg;
        dir_nxt  = dir;
        cnt_nxt  = div_cnt;
        if (en) begin
            gain_nxt = g_eff;
            dir_nxt  = dir_eff;
            cnt_nxt  = cnt_eff;
            if (valid_in) begin
                if (cnt_eff == hold_div) begin
                    cnt_nxt = '0;
                    if (gain_min >= gain_max) begin
                        gain_nxt = gain_min;
                        dir_nxt  = ~dir_eff;
                    end else if (dir_eff) begin
                        if (up_sum >= {1'b0, gain_max}) begin
                            gain_nxt = gain_max;
                            dir_nxt  = 1'b0;
                        end else begin
                            gain_nxt = up_sum[GWIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, g_eff} <= down_lim) begin
                            gain_nxt = gain_min;
                            dir_nxt  = 1'b1;
                        end else begin
                            gain_nxt = g_eff - gain_step;
                        end
                    end
                end else begin
                    cnt_nxt = cnt_eff + DWIDTH'(1);
                end
            end
        end
    end

    // Returns {saturated, value}: round half up, then clamp to WIDTH bits.
    function automatic logic [WIDTH:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] r;
        r = ((PW+1)'(p) + RND) >>> (GWIDTH-1);
        if (r > SMAX)      return {1'b1, SMAX[WIDTH-1:0]};
        else if (r < SMIN) return {1'b1, SMIN[WIDTH-1:0]};
        else               return {1'b0, r[WIDTH-1:0]};
    endfunction

    assign res_i = round_sat(p1_i);
    assign res_q = round_sat(p1_q);

    // NOTE: product registers carry no reset; v1 alone qualifies them.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            p1_i <= PW'(i_in) * PW'($signed({1'b0, g_eff}));
            p1_q <= PW'(q_in) * PW'($signed({1'b0, g_eff}));
        end
    end

    // NOTE: sequential state uses non-blocking assignments throughout.
    always_ff @(posedge clk) begin
        if (rst) begin
            gain_reg  <= UNITY;
            dir       <= 1'b1;
            div_cnt   <= '0;
            en_d      <= 1'b0;
            v1        <= 1'b0;
            valid_out <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sat       <= 1'b0;
        end else begin
            gain_reg  <= gain_nxt;
            dir       <= dir_nxt;
            div_cnt   <= cnt_nxt;
            en_d      <= en;
            v1        <= valid_in;
            valid_out <= v1;
            if (v1) begin
                i_out <= res_i[WIDTH-1:0];
                q_out <= res_q[WIDTH-1:0];
                sat   <= res_i[WIDTH] | res_q[WIDTH];
            end
        end
    end

    assign gain_out = gain_reg;
    assign dir_out  = dir;

endmodule

// File: tb/tb_iq_gain_sweep.sv
// Table-driven bench for iq_gain_sweep: each record drives one cycle and
// lists the outputs expected just after that cycle's rising edge.
module tb_iq_gain_sweep;

    logic               clk = 1'b0;
    logic               rst, en, valid_in;
    logic [15:0]        gain_min, gain_max, gain_step, hold_div;
    logic signed [11:0] i_in, q_in;
    logic signed [11:0] i_out, q_out;
    logic               valid_out, sat, dir_out;
    logic [15:0]        gain_out;

    iq_gain_sweep #(.WIDTH(12), .GWIDTH(16), .DWIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .gain_min(gain_min), .gain_max(gain_max), .gain_step(gain_step),
        .hold_div(hold_div), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
        .i_out(i_out), .q_out(q_out), .valid_out(valid_out), .sat(sat),
        .gain_out(gain_out), .dir_out(dir_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   gmin, gmax, gstep, hold;
        logic en, valid;
        int   i, q;
        logic exp_vo;
        int   exp_i, exp_q;
        logic exp_sat;
        int   exp_gain;
        logic exp_dir;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   c_min, c_max, c_step, c_hold;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int mn, input int mx, input int st, input int hd);
        c_min = mn; c_max = mx; c_step = st; c_hold = hd;
    endtask

    function automatic vec_t mk(input logic e, input logic v, input int i, input int q,
                                input logic vo, input int ei, input int eq,
                                input logic es, input int eg, input logic ed);
        vec_t r;
        r.gmin = c_min; r.gmax = c_max; r.gstep = c_step; r.hold = c_hold;
        r.en = e; r.valid = v; r.i = i; r.q = q;
        r.exp_vo = vo; r.exp_i = ei; r.exp_q = eq; r.exp_sat = es;
        r.exp_gain = eg; r.exp_dir = ed;
        return r;
    endfunction

    task automatic drive(input logic r, input logic e, input logic v,
                         input int i, input int q);
        rst = r; en = e; valid_in = v;
        i_in = 12'(i); q_in = 12'(q);
        gain_min = 16'(c_min); gain_max = 16'(c_max);
        gain_step = 16'(c_step); hold_div = 16'(c_hold);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic vo, input int ei, input int eq,
                             input logic es, input int eg, input logic ed);
        check({tag, " valid_out"}, 32'(valid_out), 32'(vo));
        check({tag, " i_out"},     32'(i_out),     32'(ei));
        check({tag, " q_out"},     32'(q_out),     32'(eq));
        check({tag, " sat"},       32'(sat),       32'(es));
        check({tag, " gain_out"},  32'(gain_out),  32'(eg));
        check({tag, " dir_out"},   32'(dir_out),   32'(ed));
    endtask

    initial begin
        // Unity pass-through with the sweep disabled
        cfg(16384, 32768, 4096, 0);
        tbl.push_back(mk(0, 1, 1000, -1000, 0,    0,     0, 0, 32768, 1));
        tbl.push_back(mk(0, 1, 1000, -1000, 1, 1000, -1000, 0, 32768, 1));
        tbl.push_back(mk(0, 0,    0,     0, 1, 1000, -1000, 0, 32768, 1));
        tbl.push_back(mk(0, 0,    0,     0, 0, 1000, -1000, 0, 32768, 1));
        // Triangle 16384..32768 in steps of 4096, one step per sample
        tbl.push_back(mk(1, 1, 1000, -1000, 0, 1000, -1000, 0, 20480, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  500,  -500, 0, 24576, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  625,  -625, 0, 28672, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  750,  -750, 0, 32768, 0));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  875,  -875, 0, 28672, 0));
        tbl.push_back(mk(1, 1, 1000, -1000, 1, 1000, -1000, 0, 24576, 0));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  875,  -875, 0, 20480, 0));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  750,  -750, 0, 16384, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  625,  -625, 0, 20480, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 1,  500,  -500, 0, 24576, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  625,  -625, 0, 24576, 1));
        tbl.push_back(mk(1, 0,    0,     0, 0,  625,  -625, 0, 24576, 1));
        // Rate: hold_div=3, samples on alternate cycles
        cfg(16384, 32768, 4096, 3);
        tbl.push_back(mk(0, 0,    0,     0, 0,  625,  -625, 0, 24576, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 0,  625,  -625, 0, 16384, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  500,  -500, 0, 16384, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 0,  500,  -500, 0, 16384, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  500,  -500, 0, 16384, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 0,  500,  -500, 0, 16384, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  500,  -500, 0, 16384, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 0,  500,  -500, 0, 20480, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  500,  -500, 0, 20480, 1));
        tbl.push_back(mk(1, 1, 1000, -1000, 0,  500,  -500, 0, 20480, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  625,  -625, 0, 20480, 1));
        // Saturation at maximum gain, pinned limits
        cfg(65535, 65535, 4096, 0);
        tbl.push_back(mk(0, 0,    0,     0, 0,  625,  -625, 0, 20480, 1));
        tbl.push_back(mk(1, 1, 2047, -2048, 0,  625,  -625, 0, 65535, 0));
        tbl.push_back(mk(1, 1,  100,   100, 1, 2047, -2048, 1, 65535, 1));
        tbl.push_back(mk(1, 0,    0,     0, 1,  200,   200, 0, 65535, 1));
        tbl.push_back(mk(1, 0,    0,     0, 0,  200,   200, 0, 65535, 1));
        // Inverted limits: gain pinned at gain_min, direction toggles
        cfg(40000, 20000, 1000, 0);
        tbl.push_back(mk(0, 0,    0,     0, 0,  200,   200, 0, 65535, 1));
        tbl.push_back(mk(1, 1, 1000,  1000, 0,  200,   200, 0, 40000, 0));
        tbl.push_back(mk(1, 1, 1000,  1000, 1, 1221,  1221, 0, 40000, 1));
        tbl.push_back(mk(1, 1, 1000,  1000, 1, 1221,  1221, 0, 40000, 0));
        tbl.push_back(mk(1, 0,    0,     0, 1, 1221,  1221, 0, 40000, 0));
        tbl.push_back(mk(1, 0,    0,     0, 0, 1221,  1221, 0, 40000, 0));

        cfg(16384, 32768, 4096, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_all("reset", 0, 0, 0, 0, 32768, 1);

        foreach (tbl[k]) begin
            c_min = tbl[k].gmin; c_max = tbl[k].gmax;
            c_step = tbl[k].gstep; c_hold = tbl[k].hold;
            drive(0, tbl[k].en, tbl[k].valid, tbl[k].i, tbl[k].q);
            check_all($sformatf("vec%0d", k), tbl[k].exp_vo, tbl[k].exp_i,
                      tbl[k].exp_q, tbl[k].exp_sat, tbl[k].exp_gain, tbl[k].exp_dir);
        end

        // Reset mid-sweep with en and valid_in held high, then restart
        cfg(16384, 32768, 4096, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 1000, -1000);
        drive(0, 1, 1, 1000, -1000);
        drive(0, 1, 1, 1000, -1000);
        check({"pre_rst gain_out"}, 32'(gain_out), 32'(28672));
        drive(1, 1, 1, 1000, -1000);
        check_all("rst_mid", 0, 0, 0, 0, 32768, 1);
        drive(0, 1, 0, 0, 0);
        check_all("rst_rel1", 0, 0, 0, 0, 16384, 1);
        drive(0, 1, 1, 1000, -1000);
        check_all("rst_rel2", 0, 0, 0, 0, 20480, 1);
        drive(0, 1, 0, 0, 0);
        check_all("rst_rel3", 1, 500, -500, 0, 20480, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
